// File: rtl/change_event_pkg.sv
// Shared types and default sizes for the change event logger.
//   ev_rec_t      : one event record {a_chg, b_chg, a_val, b_val}
//   DEFAULT_DEPTH : default event FIFO depth
//   DEFAULT_CNT_W : default width of the per-signal change counters
package change_event_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    typedef struct packed {
        logic a_chg;
        logic b_chg;
        logic a_val;
        logic b_val;
    } ev_rec_t;

endpackage

// File: rtl/change_event_logger_fifo.sv
// event_fifo: synchronous FIFO for event records, with no bypass path.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : write request, wr_data_i is the record to store
//   pop_i       : read request, honoured only when not empty
//   rd_data_o   : head record, forced to zero while empty
//   valid_o     : FIFO not empty
//   drop_o      : push rejected this cycle (full and no pop)
module event_fifo
    import change_event_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    parameter type rec_t = ev_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  rec_t wr_data_i,
    input  logic pop_i,
    output rec_t rd_data_o,
    output logic valid_o,
    output logic drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra MSB so full and empty can be told apart
    // when the index bits are equal.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    rec_t        mem_q [DEPTH];

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty;
    // A pop frees the slot in the same cycle, so push and pop both succeed
    // when full.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign valid_o   = !empty;
    assign rd_data_o = empty ? rec_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/change_event_logger.sv
// change_event_logger: samples two signals every clock, queues a record for
// each cycle in which either changed, and counts changes per signal.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   a, b         : monitored signals
//   clr          : synchronous clear of counters and overflow flag
//   ev_valid     : record available on ev_data
//   ev_ready     : consumer accepts the record (pop on valid & ready)
//   ev_data      : {a_chg, b_chg, a_val, b_val}
//   a_cnt, b_cnt : saturating change counters
//   overflow     : sticky, a record was dropped because the FIFO was full
module change_event_logger
    import change_event_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [3:0]       ev_data,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             a_q, b_q;
    logic             a_chg, b_chg;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic             drop;
    ev_rec_t          rec_in;
    ev_rec_t          rec_out;

    assign a_chg = a ^ a_q;
    assign b_chg = b ^ b_q;
    assign push  = a_chg | b_chg;

    always_comb begin
        rec_in       = '0;
        rec_in.a_chg = a_chg;
        rec_in.b_chg = b_chg;
        rec_in.a_val = a;
        rec_in.b_val = b;
    end

    // clr takes priority over a coincident change; the record is still queued.
    always_comb begin
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        overflow_d = overflow_q | drop;
        if (clr) begin
            a_cnt_d    = '0;
            b_cnt_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (a_chg && (a_cnt_q != '1)) begin
                a_cnt_d = a_cnt_q + CNT_ONE;
            end
            if (b_chg && (b_cnt_q != '1)) begin
                b_cnt_d = b_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            a_q        <= a;
            b_q        <= b;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .rec_t (ev_rec_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .wr_data_i (rec_in),
        .pop_i     (ev_ready),
        .rd_data_o (rec_out),
        .valid_o   (ev_valid),
        .drop_o    (drop)
    );

    assign ev_data  = rec_out;
    assign a_cnt    = a_cnt_q;
    assign b_cnt    = b_cnt_q;
    assign overflow = overflow_q;

endmodule
